// File: rtl/booth_mult_seq_if.sv
// Handshake/operand bundle for booth_mult_seq.
//  start         request, honoured only when the multiplier is idle or done
//  is_signed     1: two's complement operands, 0: unsigned
//  multiplicand  M operand, WIDTH bits
//  multiplier    Q operand, WIDTH bits
//  busy          high while iterating
//  done          one-cycle completion pulse
//  product       2*WIDTH-bit result, held until the next completion
interface booth_mult_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   start;
    logic                   is_signed;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    // Requester side
    modport master (
        output start, is_signed, multiplicand, multiplier,
        input  busy, done, product
    );

    // Multiplier side
    modport slave (
        input  start, is_signed, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one add/sub-and-shift step per clock.
// Operands are widened by one bit (sign or zero) so a single Booth datapath
// serves both signed and unsigned modes; WIDTH+1 iterations give the result.
//  clk    rising-edge clock
//  n_rst  asynchronous active-low reset
//  bus    booth_mult_seq_if.slave: start/is_signed/operands in,
//         busy/done/product out (all registered)
module booth_mult_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    booth_mult_seq_if.slave        bus
);
    localparam int unsigned EW = WIDTH + 1;        // extended operand width
    localparam int unsigned AW = WIDTH + 2;        // accumulator width
    localparam int unsigned PW = 2 * WIDTH;        // product width
    localparam int unsigned CW = $clog2(WIDTH + 2); // iteration counter width

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_busy;
    logic            r_done;
    logic [PW-1:0]   r_product;
    logic [AW-1:0]   r_a;
    logic [AW-1:0]   r_m;
    logic [EW-1:0]   r_q;
    logic            r_q_m1;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_last;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_m_sgn;
    logic            w_q_sgn;
    logic [AW-1:0]   w_sum;
    logic [AW-1:0]   w_a_sh;
    logic [EW-1:0]   w_q_sh;
    logic [PW-1:0]   w_prod;

    // Request is only honoured outside RUN; the final step runs with cnt==1
    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(1));

    // State register plus registered status outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the upcoming state so they can be registered
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        if (w_state_nxt == S_RUN)  w_busy_nxt = 1'b1;
        if (w_state_nxt == S_DONE) w_done_nxt = 1'b1;
    end

    // Booth step: recode {Q0, q_-1}, add/sub M, then arithmetic shift right
    always_comb begin
        w_m_sgn = bus.is_signed & bus.multiplicand[WIDTH-1];
        w_q_sgn = bus.is_signed & bus.multiplier[WIDTH-1];
        unique case ({r_q[0], r_q_m1})
            2'b10:   w_sum = r_a - r_m;
            2'b01:   w_sum = r_a + r_m;
            default: w_sum = r_a;
        endcase
        w_a_sh = {w_sum[AW-1], w_sum[AW-1:1]};
        w_q_sh = {w_sum[0], r_q[EW-1:1]};
        // Low 2*WIDTH bits of the shifted {A, Q} pair
        w_prod = {w_a_sh[WIDTH-2:0], w_q_sh};
    end

    // Datapath registers; product only moves on the final step
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_q_m1    <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a    <= '0;
            r_m    <= {{2{w_m_sgn}}, bus.multiplicand};
            r_q    <= {w_q_sgn, bus.multiplier};
            r_q_m1 <= 1'b0;
            r_cnt  <= CW'(WIDTH + 1);
        end else if (r_state == S_RUN) begin
            r_a    <= w_a_sh;
            r_q    <= w_q_sh;
            r_q_m1 <= r_q[0];
            r_cnt  <= r_cnt - CW'(1);
            if (w_last) r_product <= w_prod;
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq at WIDTH = 4, 8 and 16.
module tb_booth_mult_seq;
    logic clk = 1'b0;
    logic n_rst;
    int   n_err = 0;
    int   n_chk = 0;
    logic [31:0] prev_p [3];

    always #5 clk = ~clk;

    booth_mult_seq_if #(.WIDTH(4))  if4  ();
    booth_mult_seq_if #(.WIDTH(8))  if8  ();
    booth_mult_seq_if #(.WIDTH(16)) if16 ();

    booth_mult_seq #(.WIDTH(4))  u_dut4  (.clk(clk), .n_rst(n_rst), .bus(if4));
    booth_mult_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .n_rst(n_rst), .bus(if8));
    booth_mult_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .n_rst(n_rst), .bus(if16));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int idx(input int w);
        return (w == 4) ? 0 : (w == 8) ? 1 : 2;
    endfunction

    // Exact product from integer arithmetic, truncated to 2*w bits
    function automatic logic [31:0] ref_prod(input int w, input logic sg,
                                             input logic [15:0] m, input logic [15:0] q);
        longint lim, mv, qv, p;
        lim = longint'(1) << w;
        mv  = longint'(m) & (lim - 1);
        qv  = longint'(q) & (lim - 1);
        if (sg && mv >= lim / 2) mv = mv - lim;
        if (sg && qv >= lim / 2) qv = qv - lim;
        p = (mv * qv) & ((longint'(1) << (2 * w)) - 1);
        return 32'(p);
    endfunction

    task automatic drive(input int w, input logic st, input logic sg,
                         input logic [15:0] m, input logic [15:0] q);
        case (w)
            4: begin if4.start = st; if4.is_signed = sg; if4.multiplicand = m[3:0]; if4.multiplier = q[3:0]; end
            8: begin if8.start = st; if8.is_signed = sg; if8.multiplicand = m[7:0]; if8.multiplier = q[7:0]; end
            default: begin if16.start = st; if16.is_signed = sg; if16.multiplicand = m; if16.multiplier = q; end
        endcase
    endtask

    function automatic logic get_busy(input int w);
        return (w == 4) ? if4.busy : (w == 8) ? if8.busy : if16.busy;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 4) ? if4.done : (w == 8) ? if8.done : if16.done;
    endfunction

    function automatic logic [31:0] get_prod(input int w);
        return (w == 4) ? 32'(if4.product) : (w == 8) ? 32'(if8.product) : 32'(if16.product);
    endfunction

    // Called at the negedge right after the accepting edge; lat = edges to done
    task automatic wait_done(input int w, output int lat, output int nbusy);
        lat = -1;
        nbusy = 0;
        for (int c = 0; c < w + 6; c++) begin
            if (c > 0) @(negedge clk);
            if (get_done(w)) begin
                lat = c;
                break;
            end
            if (get_busy(w)) nbusy++;
        end
    endtask

    // One complete operation with latency, busy, hold and pulse checks
    task automatic run_op(input int w, input logic sg, input logic [15:0] m,
                          input logic [15:0] q, input logic [31:0] exp, input string tag);
        int lat, nbusy;
        @(negedge clk);
        drive(w, 1'b1, sg, m, q);
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs to prove they were captured at accept
        drive(w, 1'b0, ~sg, ~m, ~q);
        chk({tag, "_hold"}, get_prod(w), prev_p[idx(w)]);
        wait_done(w, lat, nbusy);
        chk({tag, "_lat"}, 32'(lat), 32'(w + 1));
        chk({tag, "_busy"}, 32'(nbusy), 32'(w + 1));
        chk({tag, "_busy_in_done"}, 32'(get_busy(w)), 32'd0);
        chk({tag, "_prod"}, get_prod(w), exp);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(get_done(w)), 32'd0);
        prev_p[idx(w)] = exp;
    endtask

    function automatic logic [15:0] pick(input int w);
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 9))
            0: v = 16'h0000;
            1: v = 16'hFFFF;
            2: v = 16'(1) << (w - 1);
            3: v = (16'(1) << (w - 1)) - 16'd1;
            default: ;
        endcase
        return v & ((16'(1) << w) - 16'd1);
    endfunction

    initial begin
        int lat, nbusy, ndone;
        int widths [3];
        logic [31:0] got;
        logic [15:0] m, q;
        logic        sg;
        widths = '{4, 8, 16};
        foreach (prev_p[i]) prev_p[i] = '0;
        foreach (widths[i]) drive(widths[i], 1'b0, 1'b0, 16'd0, 16'd0);
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(if8.busy), 32'd0);
        chk("rst_done", 32'(if8.done), 32'd0);
        chk("rst_prod8", get_prod(8), 32'd0);
        chk("rst_prod4", get_prod(4), 32'd0);
        chk("rst_prod16", get_prod(16), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // Directed corner operands
        run_op(8, 1'b0, 16'h00FF, 16'h00FF, 32'hFE01, "u_ff_ff");
        run_op(8, 1'b1, 16'h0080, 16'h0080, 32'h4000, "s_min_min");
        run_op(8, 1'b1, 16'h0080, 16'h007F, 32'hC080, "s_min_max");
        run_op(8, 1'b1, 16'h0005, 16'h00FD, 32'hFFF1, "s_5_m3");
        run_op(8, 1'b0, 16'h0005, 16'h00FD, 32'h04F1, "u_5_253");

        // Start during RUN is ignored
        @(negedge clk);
        drive(8, 1'b1, 1'b0, 16'd12, 16'd13);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, 1'b0, 16'd12, 16'd13);
        repeat (3) @(negedge clk);
        drive(8, 1'b1, 1'b0, 16'd200, 16'd200);
        @(negedge clk);
        drive(8, 1'b0, 1'b0, 16'd200, 16'd200);
        ndone = 0;
        got = '0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (if8.done) begin
                ndone++;
                got = get_prod(8);
            end
        end
        chk("run_ign_pulses", 32'(ndone), 32'd1);
        chk("run_ign_prod", got, 32'h009C);
        chk("run_ign_keep", get_prod(8), 32'h009C);

        // Back-to-back: start held through DONE
        @(negedge clk);
        drive(8, 1'b1, 1'b1, 16'h00FE, 16'h0007);
        @(posedge clk);
        @(negedge clk);
        wait_done(8, lat, nbusy);
        chk("b2b_lat1", 32'(lat), 32'd9);
        chk("b2b_prod1", get_prod(8), 32'hFFF2);
        drive(8, 1'b1, 1'b0, 16'd17, 16'd3);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
        wait_done(8, lat, nbusy);
        chk("b2b_lat2", 32'(lat), 32'd9);
        chk("b2b_busy2", 32'(nbusy), 32'd9);
        chk("b2b_prod2", get_prod(8), 32'h0033);
        prev_p[1] = 32'h0033;
        @(negedge clk);

        // Reset mid-RUN with four iterations still pending
        @(negedge clk);
        drive(8, 1'b1, 1'b1, 16'd100, 16'hCE);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, 1'b1, 16'd100, 16'hCE);
        repeat (5) @(negedge clk);
        chk("mid_busy_pre", 32'(if8.busy), 32'd1);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(if8.busy), 32'd0);
        chk("mid_rst_done", 32'(if8.done), 32'd0);
        chk("mid_rst_prod", get_prod(8), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (if8.done) ndone++;
        end
        chk("mid_rst_nodone", 32'(ndone), 32'd0);
        foreach (prev_p[i]) prev_p[i] = '0;
        run_op(8, 1'b1, 16'd100, 16'hCE, 32'hEC78, "post_rst");

        // Randomized operands and modes against the arithmetic model
        foreach (widths[i]) begin
            for (int n = 0; n < 1200; n++) begin
                m  = pick(widths[i]);
                q  = pick(widths[i]);
                sg = 1'($urandom_range(0, 1));
                run_op(widths[i], sg, m, q, ref_prod(widths[i], sg, m, q), "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
